mips_stage_controller: RTL and testbench

- Multi-cycle sequencer for the MIPS datapath. Drives the 3-bit `stage` bus consumed by the ALU, which computes only when `stage == 2`.
- Decodes the opcode into `alu_op` / `alu_src` and the memory and writeback strobes.
- Handshakes with instruction/data memory and counts retired instructions.
- Sits between the instruction register and the ALU, register file and memory.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/mips_opcode_decode.sv | 58 +++++
 rtl/mips_stage_controller.sv | 215 +++++++++++++++++++++
 tb/tb_mips_stage_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: stage codes, opcode
// constants, ALU operation selects, PC source selects and opcode classes.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_IDLE = 3'd7
    } stage_e;

    typedef enum logic [2:0] {
        CL_RTYPE   = 3'd0,
        CL_LW      = 3'd1,
        CL_SW      = 3'd2,
        CL_ADDI    = 3'd3,
        CL_BEQ     = 3'd4,
        CL_J       = 3'd5,
        CL_ILLEGAL = 3'd6
    } op_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_opcode_decode.sv
// Combinational opcode decoder: instruction class plus the ALU and writeback
// selects that class implies. Unknown opcodes decode as illegal.
module mips_opcode_decode
    import mips_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opcode_i,
    output logic [2:0]       op_class_o,
    output logic [1:0]       alu_op_o,
    output logic             alu_src_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             legal_o
);

    // Opcode to class and datapath selects
    always_comb begin
        op_class_o   = CL_ILLEGAL;
        alu_op_o     = ALU_ADD;
        alu_src_o    = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        legal_o      = 1'b1;
        case (opcode_i)
            OP_RTYPE: begin
                op_class_o = CL_RTYPE;
                alu_op_o   = ALU_FUNCT;
                reg_dst_o  = 1'b1;
            end
            OP_LW: begin
                op_class_o   = CL_LW;
                alu_src_o    = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            OP_SW: begin
                op_class_o = CL_SW;
                alu_src_o  = 1'b1;
            end
            OP_ADDI: begin
                op_class_o = CL_ADDI;
                alu_src_o  = 1'b1;
            end
            OP_BEQ: begin
                op_class_o = CL_BEQ;
                alu_op_o   = ALU_SUB;
            end
            OP_J: begin
                op_class_o = CL_J;
            end
            default: begin
                op_class_o = CL_ILLEGAL;
                legal_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_stage_controller.sv
// Multi-cycle sequencer: walks IF/ID/EX/MEM/WB, drives datapath strobes,
// handshakes with memory and counts retired instructions.
module mips_stage_controller
    import mips_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int OPC_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    input  logic             zero,
    output logic [2:0]       stage,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    stage_e             state_q, state_d;
    logic [OPC_W-1:0]   opcode_q, opcode_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic               alu_src_q, alu_src_d;
    logic               reg_dst_q, reg_dst_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic [OPC_W-1:0]   dec_opcode_s;
    logic [2:0]         dec_class_s;
    logic [1:0]         dec_alu_op_s;
    logic               dec_alu_src_s;
    logic               dec_reg_dst_s;
    logic               dec_mem_to_reg_s;
    logic               dec_legal_s;

    logic               ir_write_s;
    logic               pc_write_s;
    logic [1:0]         pc_src_s;
    logic               mem_read_s;
    logic               mem_write_s;
    logic               reg_write_s;
    logic               illegal_s;
    logic               complete_s;
    stage_e             boundary_s;

    // ID decodes the live IR field; later stages use the opcode latched in ID.
    assign dec_opcode_s = (state_q == ST_ID) ? opcode : opcode_q;
    assign boundary_s   = run ? ST_IF : ST_IDLE;

    mips_opcode_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .opcode_i     (dec_opcode_s),
        .op_class_o   (dec_class_s),
        .alu_op_o     (dec_alu_op_s),
        .alu_src_o    (dec_alu_src_s),
        .reg_dst_o    (dec_reg_dst_s),
        .mem_to_reg_o (dec_mem_to_reg_s),
        .legal_o      (dec_legal_s)
    );

    // Next-state, combinational strobes and register next values
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        alu_op_d     = alu_op_q;
        alu_src_d    = alu_src_q;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = PC_SRC_PLUS4;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        illegal_s    = 1'b0;
        complete_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_IF;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IF: begin
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = ST_ID;
                end else begin
                    state_d = ST_IF;
                end
            end
            ST_ID: begin
                opcode_d = opcode;
                if (!dec_legal_s) begin
                    illegal_s = 1'b1;
                    state_d   = boundary_s;
                end else begin
                    alu_op_d  = dec_alu_op_s;
                    alu_src_d = dec_alu_src_s;
                    if (dec_class_s == CL_J) begin
                        pc_write_s = 1'b1;
                        pc_src_s   = PC_SRC_JUMP;
                        complete_s = 1'b1;
                        state_d    = boundary_s;
                    end else begin
                        state_d = ST_EX;
                    end
                end
            end
            ST_EX: begin
                if ((dec_class_s == CL_RTYPE) || (dec_class_s == CL_ADDI)) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_MEM: begin
                case (dec_class_s)
                    CL_LW: begin
                        mem_read_s = 1'b1;
                        if (mem_ready) begin
                            state_d = ST_WB;
                        end else begin
                            state_d = ST_MEM;
                        end
                    end
                    CL_SW: begin
                        mem_write_s = 1'b1;
                        if (mem_ready) begin
                            complete_s = 1'b1;
                            state_d    = boundary_s;
                        end else begin
                            state_d = ST_MEM;
                        end
                    end
                    CL_BEQ: begin
                        if (zero) begin
                            pc_write_s = 1'b1;
                            pc_src_s   = PC_SRC_BRANCH;
                        end else begin
                            pc_write_s = 1'b0;
                        end
                        complete_s = 1'b1;
                        state_d    = boundary_s;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
            ST_WB: begin
                reg_write_s = 1'b1;
                complete_s  = 1'b1;
                state_d     = boundary_s;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Writeback selects are Moore outputs valid only while in WB
    assign reg_dst_d    = (state_d == ST_WB) && dec_reg_dst_s;
    assign mem_to_reg_d = (state_d == ST_WB) && dec_mem_to_reg_s;
    assign retired_d    = complete_s ? (retired_q + {{(CNT_W-1){1'b0}}, 1'b1}) : retired_q;

    // State, latched opcode, registered selects and retire counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            opcode_q     <= {OPC_W{1'b0}};
            alu_op_q     <= ALU_ADD;
            alu_src_q    <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            retired_q    <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            alu_op_q     <= alu_op_d;
            alu_src_q    <= alu_src_d;
            reg_dst_q    <= reg_dst_d;
            mem_to_reg_q <= mem_to_reg_d;
            retired_q    <= retired_d;
        end
    end

    assign stage      = state_q;
    assign alu_op     = alu_op_q;
    assign alu_src    = alu_src_q;
    assign reg_dst    = reg_dst_q;
    assign mem_to_reg = mem_to_reg_q;
    assign retired    = retired_q;

    // A cycle with reset asserted must never commit a partial write
    assign ir_write   = ir_write_s  & reset_n;
    assign pc_write   = pc_write_s  & reset_n;
    assign pc_src     = reset_n ? pc_src_s : PC_SRC_PLUS4;
    assign mem_read   = mem_read_s  & reset_n;
    assign mem_write  = mem_write_s & reset_n;
    assign reg_write  = reg_write_s & reset_n;
    assign illegal_op = illegal_s   & reset_n;

endmodule

// File: tb/tb_mips_stage_controller.sv
// Directed-vector bench for mips_stage_controller: per-cycle stage, strobe and
// registered-select expectations plus retired-count checkpoints.
module tb_mips_stage_controller;

    logic        clock;
    logic        reset_n;
    logic        run;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        zero;
    logic [2:0]  stage;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        illegal_op;
    logic [31:0] retired;

    int checks_q   = 0;
    int failures_q = 0;

    logic [7:0] strb_s;
    logic [4:0] regs_s;

    mips_stage_controller #(
        .CNT_W (32),
        .OPC_W (6)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (run),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .stage      (stage),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .illegal_op (illegal_op),
        .retired    (retired)
    );

    // {ir_write, pc_write, pc_src, mem_read, mem_write, reg_write, illegal_op}
    assign strb_s = {ir_write, pc_write, pc_src, mem_read, mem_write, reg_write, illegal_op};
    // {alu_op, alu_src, reg_dst, mem_to_reg}
    assign regs_s = {alu_op, alu_src, reg_dst, mem_to_reg};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_q = checks_q + 1;
        if (obs !== exp) begin
            failures_q = failures_q + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check one cycle mid-period, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [7:0] strb,
                       input logic [4:0] rg);
        #1;
        check({tag, ".stage"}, 32'(stage), 32'(st));
        check({tag, ".strb"},  32'(strb_s), 32'(strb));
        check({tag, ".regs"},  32'(regs_s), 32'(rg));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; run = 1'b0; opcode = 6'b000000; mem_ready = 1'b0; zero = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        cyc("rst", 3'd7, 8'h00, 5'b00000);
        check("rst.retired", retired, 32'd0);
        reset_n = 1'b1;
        cyc("idle0", 3'd7, 8'h00, 5'b00000);
        run = 1'b1; opcode = 6'b000000; mem_ready = 1'b1;
        cyc("idle1", 3'd7, 8'h00, 5'b00000);

        // R-type
        cyc("r.if", 3'd0, 8'hC0, 5'b00000);
        cyc("r.id", 3'd1, 8'h00, 5'b00000);
        cyc("r.ex", 3'd2, 8'h00, 5'b10000);
        check("r.ret_wb", retired, 32'd0);
        cyc("r.wb", 3'd4, 8'h02, 5'b10010);
        check("r.retired", retired, 32'd1);

        // lw with three MEM stall cycles
        opcode = 6'b100011;
        cyc("lw.if", 3'd0, 8'hC0, 5'b10000);
        cyc("lw.id", 3'd1, 8'h00, 5'b10000);
        mem_ready = 1'b0;
        cyc("lw.ex", 3'd2, 8'h00, 5'b00100);
        cyc("lw.mem0", 3'd3, 8'h08, 5'b00100);
        cyc("lw.mem1", 3'd3, 8'h08, 5'b00100);
        cyc("lw.mem2", 3'd3, 8'h08, 5'b00100);
        mem_ready = 1'b1;
        cyc("lw.mem3", 3'd3, 8'h08, 5'b00100);
        cyc("lw.wb", 3'd4, 8'h02, 5'b00101);
        check("lw.retired", retired, 32'd2);

        // beq taken
        opcode = 6'b000100;
        cyc("beq1.if", 3'd0, 8'hC0, 5'b00100);
        cyc("beq1.id", 3'd1, 8'h00, 5'b00100);
        zero = 1'b1;
        cyc("beq1.ex", 3'd2, 8'h00, 5'b01000);
        cyc("beq1.mem", 3'd3, 8'h50, 5'b01000);
        check("beq1.retired", retired, 32'd3);

        // beq not taken
        zero = 1'b0;
        cyc("beq0.if", 3'd0, 8'hC0, 5'b01000);
        cyc("beq0.id", 3'd1, 8'h00, 5'b01000);
        cyc("beq0.ex", 3'd2, 8'h00, 5'b01000);
        cyc("beq0.mem", 3'd3, 8'h00, 5'b01000);
        check("beq0.retired", retired, 32'd4);

        // j, then an illegal opcode
        opcode = 6'b000010;
        cyc("j.if", 3'd0, 8'hC0, 5'b01000);
        cyc("j.id", 3'd1, 8'h60, 5'b01000);
        check("j.retired", retired, 32'd5);
        opcode = 6'b111111;
        cyc("ill.if", 3'd0, 8'hC0, 5'b00000);
        cyc("ill.id", 3'd1, 8'h01, 5'b00000);
        check("ill.retired", retired, 32'd5);

        // sw, stopping at the instruction boundary
        opcode = 6'b101011;
        cyc("sw.if", 3'd0, 8'hC0, 5'b00000);
        cyc("sw.id", 3'd1, 8'h00, 5'b00000);
        cyc("sw.ex", 3'd2, 8'h00, 5'b00100);
        run = 1'b0;
        cyc("sw.mem", 3'd3, 8'h04, 5'b00100);
        check("sw.retired", retired, 32'd6);
        cyc("sw.idle", 3'd7, 8'h00, 5'b00100);

        // reset during a lw MEM stall
        run = 1'b1; opcode = 6'b100011;
        cyc("rl.idle", 3'd7, 8'h00, 5'b00100);
        cyc("rl.if", 3'd0, 8'hC0, 5'b00100);
        cyc("rl.id", 3'd1, 8'h00, 5'b00100);
        mem_ready = 1'b0;
        cyc("rl.ex", 3'd2, 8'h00, 5'b00100);
        cyc("rl.mem", 3'd3, 8'h08, 5'b00100);
        reset_n = 1'b0;
        cyc("rl.rst", 3'd3, 8'h00, 5'b00100);
        check("rl.retired", retired, 32'd0);
        reset_n = 1'b1; run = 1'b0;
        cyc("rl.after", 3'd7, 8'h00, 5'b00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
        $finish;
    end

endmodule
